arp_vlg_tx: RTL and testbench
=============================

// Module: arp_vlg_tx
// PURPOSE
//  ARP transmitter: serializes ARP requests/replies (arp_hdr_t layout) into a byte stream for the MAC TX path.
//  Reply is triggered by the ARP RX path or a responder; request by the ARP table on a miss.
//  Sits between ARP logic and mac_vlg_tx; drives the MAC destination and ethertype (ARP, 16'h0806) sideband.
// PARAMETERS
//  PAD_LEN  46  min frame payload bytes; zero padding after 28-byte header; total = max(28, PAD_LEN)
// PORTS
//  clk           in   1   clock
//  rst           in   1   synchronous active-high reset
//  dev_mac       in   48  local MAC (mac_addr_t), sampled at frame start
//  dev_ipv4      in   32  local IPv4 (ipv4_t), sampled at frame start
//  req_v         in   1   pulse: send ARP request for req_ipv4
//  req_ipv4      in   32  target IPv4 for request
//  rep_v         in   1   pulse: send ARP reply to rep_mac/rep_ipv4
//  rep_mac       in   48  requester MAC for reply
//  rep_ipv4      in   32  requester IPv4 for reply
//  busy          out  1   frame in progress
//  done          out  1   1-cycle pulse after last byte accepted
//  tx_dat        out  8   payload byte
//  tx_val        out  1   tx_dat valid
//  tx_rdy        in   1   downstream accepts byte when tx_val & tx_rdy
//  tx_sof        out  1   first byte marker, qualified by tx_val
//  tx_eof        out  1   last byte marker, qualified by tx_val
//  tx_dst_mac    out  48  MAC dst for frame, stable whole frame
//  tx_ethertype  out  16  constant 16'h0806
// BEHAVIOUR
//  Reset: tx_val/tx_sof/tx_eof/busy/done=0, tx_dat=0, tx_dst_mac=0, pending flags cleared. tx_ethertype always 16'h0806.
//  Pending slots: one for reply, one for request. Flag set + address latched on the rep_v/req_v pulse.
//   A new pulse while pending overwrites the address; it never queues.
//  FSM states: idle_s, hdr_s, pad_s.
//  idle_s: reply pending (or rep_v this cycle) takes priority over request.
//   On start: latch dev_mac/dev_ipv4 and the selected addresses; clear that pending flag.
//   On start: next cycle enter hdr_s with tx_val=1, tx_sof=1, byte_cnt=0, busy=1.
//   Same-cycle pulse and start: the pulse is consumed directly, not left pending.
//  Header bytes, MSB first, 28 bytes:
//   hw_type 00 01; proto 08 00; hlen 06; plen 04; oper 00 01 (req) / 00 02 (rep);
//   sha=dev_mac; spa=dev_ipv4; tha=00x6 (req) / rep_mac (rep); tpa=req_ipv4 / rep_ipv4.
//  tx_dst_mac: ff:ff:ff:ff:ff:ff for a request, rep_mac for a reply.
//  byte_cnt advances only on tx_val & tx_rdy. While !tx_rdy: tx_dat/tx_sof/tx_eof held stable.
//  byte 27 accepted: go to pad_s if PAD_LEN>28, else frame ends. pad_s emits 00 up to byte PAD_LEN-1.
//  tx_eof=1 on the last byte only.
//  After the eof handshake, next cycle: tx_val=0, busy=0, done=1, state idle_s.
//   Any pending frame starts in that idle cycle, so the minimum gap between frames is 1 idle cycle.
//  rst mid-frame: next edge all outputs at reset values, pending dropped, no eof/done emitted.
//  byte_cnt width: $clog2(max(28,PAD_LEN)+1); no wrap inside a frame.
// TESTING
//  1 dev 02:00:00:00:00:01/192.168.1.10, req_v req_ipv4=192.168.1.1, tx_rdy=1 -> 46 bytes.
//    Bytes 0-7 = 00 01 08 00 06 04 00 01; 18-23 = 00; 24-27 = c0 a8 01 01; 28-45 = 00.
//    sof@0, eof@45, tx_dst_mac=ff..ff, done 1 cycle after eof.
//  2 rep_v(rep_mac=aa:bb:cc:dd:ee:ff) and req_v same cycle -> reply first.
//    Reply: oper 00 02, tha=aa..ff, tx_dst_mac=aa..ff. Then 1 idle cycle, then request frame.
//  3 tx_rdy random 50% -> byte sequence identical to case 1; tx_dat/tx_sof/tx_eof stable while tx_val & !tx_rdy.
//  4 busy; req_v ip 10.0.0.1, then req_v ip 10.0.0.2 -> exactly one extra frame, tpa 0a 00 00 02.
//  5 rst at byte 10 -> next cycle tx_val=0, busy=0; no done; no frame after rst release.
//  6 PAD_LEN=0 -> 28-byte frame, eof@27, no pad_s visited.

Source files
------------

// File: rtl/arp_vlg_tx.sv
// ARP transmitter: serializes ARP request/reply frames (28-byte header plus zero pad)
// into a byte stream with MAC destination / ethertype sideband for mac_vlg_tx.
module arp_vlg_tx #(
   parameter int unsigned PAD_LEN = 46
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [47:0] dev_mac,
   input  logic [31:0] dev_ipv4,
   input  logic        req_v,
   input  logic [31:0] req_ipv4,
   input  logic        rep_v,
   input  logic [47:0] rep_mac,
   input  logic [31:0] rep_ipv4,
   output logic        busy,
   output logic        done,
   output logic [7:0]  tx_dat,
   output logic        tx_val,
   input  logic        tx_rdy,
   output logic        tx_sof,
   output logic        tx_eof,
   output logic [47:0] tx_dst_mac,
   output logic [15:0] tx_ethertype
);

   localparam int unsigned HDR_LEN = 28;
   localparam int unsigned FRM_LEN = (PAD_LEN > HDR_LEN) ? PAD_LEN : HDR_LEN;
   localparam int unsigned CNT_W   = $clog2(FRM_LEN + 1);

   typedef enum logic [1:0] {idle_s, hdr_s, pad_s} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] byte_cnt, byte_cnt_nx;
   logic             done_nx;
   logic             start, start_rep;
   logic             accept, last_byte;

   logic             rep_pend, req_pend;
   logic [47:0]      rep_mac_q;
   logic [31:0]      rep_ipv4_q, req_ipv4_q;
   logic [47:0]      sel_rep_mac;
   logic [31:0]      sel_rep_ipv4, sel_req_ipv4;

   logic             frm_rep;
   logic [47:0]      frm_sha, frm_tha;
   logic [31:0]      frm_spa, frm_tpa;
   logic [8*HDR_LEN-1:0] hdr_vec;

   assign tx_ethertype = 16'h0806;
   assign tx_val       = (state != idle_s);
   assign busy         = tx_val;
   assign accept       = tx_val & tx_rdy;
   assign last_byte    = (byte_cnt == CNT_W'(FRM_LEN - 1));
   assign tx_sof       = tx_val & (byte_cnt == '0);
   assign tx_eof       = tx_val & last_byte;

   // A pulse arriving in the start cycle is used directly instead of the stale latch.
   assign sel_rep_mac  = rep_v ? rep_mac  : rep_mac_q;
   assign sel_rep_ipv4 = rep_v ? rep_ipv4 : rep_ipv4_q;
   assign sel_req_ipv4 = req_v ? req_ipv4 : req_ipv4_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= idle_s;
         byte_cnt <= '0;
         done     <= 1'b0;
      end else begin
         state    <= state_nx;
         byte_cnt <= byte_cnt_nx;
         done     <= done_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      byte_cnt_nx = byte_cnt;
      done_nx     = 1'b0;
      start       = 1'b0;
      start_rep   = 1'b0;
      case (state)
         idle_s: begin
            if (rep_pend | rep_v | req_pend | req_v) begin
               start       = 1'b1;
               start_rep   = rep_pend | rep_v;
               state_nx    = hdr_s;
               byte_cnt_nx = '0;
            end
         end
         hdr_s, pad_s: begin
            if (accept) begin
               if (last_byte) begin
                  state_nx    = idle_s;
                  byte_cnt_nx = '0;
                  done_nx     = 1'b1;
               end else begin
                  byte_cnt_nx = byte_cnt + 1'b1;
                  if (state == hdr_s && byte_cnt == CNT_W'(HDR_LEN - 1))
                     state_nx = pad_s;
               end
            end
         end
         default: state_nx = idle_s;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rep_pend   <= 1'b0;
         req_pend   <= 1'b0;
         rep_mac_q  <= '0;
         rep_ipv4_q <= '0;
         req_ipv4_q <= '0;
         frm_rep    <= 1'b0;
         frm_sha    <= '0;
         frm_spa    <= '0;
         frm_tha    <= '0;
         frm_tpa    <= '0;
         tx_dst_mac <= '0;
      end else begin
         if (start && start_rep) begin
            rep_pend <= 1'b0;
         end else if (rep_v) begin
            rep_pend   <= 1'b1;
            rep_mac_q  <= rep_mac;
            rep_ipv4_q <= rep_ipv4;
         end
         if (start && !start_rep) begin
            req_pend <= 1'b0;
         end else if (req_v) begin
            req_pend   <= 1'b1;
            req_ipv4_q <= req_ipv4;
         end
         if (start) begin
            frm_rep    <= start_rep;
            frm_sha    <= dev_mac;
            frm_spa    <= dev_ipv4;
            frm_tha    <= start_rep ? sel_rep_mac  : '0;
            frm_tpa    <= start_rep ? sel_rep_ipv4 : sel_req_ipv4;
            tx_dst_mac <= start_rep ? sel_rep_mac  : '1;
         end
      end
   end

   assign hdr_vec = {16'h0001, 16'h0800, 8'h06, 8'h04, 8'h00,
                     (frm_rep ? 8'h02 : 8'h01),
                     frm_sha, frm_spa, frm_tha, frm_tpa};

   always_comb begin
      tx_dat = '0;
      if (state == hdr_s) begin
         for (int unsigned i = 0; i < HDR_LEN; i++) begin
            if (byte_cnt == CNT_W'(i))
               tx_dat = hdr_vec[8*(HDR_LEN-1-i) +: 8];
         end
      end
   end

endmodule

// File: tb/tb_arp_vlg_tx.sv
// Self-checking bench for arp_vlg_tx: frames are captured byte by byte and compared
// against expected frames built from the ARP field layout.
module tb_arp_vlg_tx;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic [47:0] dev_mac = '0;
   logic [31:0] dev_ipv4 = '0;
   logic        req_v = 1'b0;
   logic [31:0] req_ipv4 = '0;
   logic        rep_v = 1'b0;
   logic [47:0] rep_mac = '0;
   logic [31:0] rep_ipv4 = '0;
   logic        tx_rdy = 1'b1;

   logic        a_busy, a_done, a_val, a_sof, a_eof;
   logic [7:0]  a_dat;
   logic [47:0] a_dst;
   logic [15:0] a_et;
   logic        b_busy, b_done, b_val, b_sof, b_eof;
   logic [7:0]  b_dat;
   logic [47:0] b_dst;
   logic [15:0] b_et;

   arp_vlg_tx u_dut (
      .clk(clk), .rst(rst), .dev_mac(dev_mac), .dev_ipv4(dev_ipv4),
      .req_v(req_v), .req_ipv4(req_ipv4), .rep_v(rep_v), .rep_mac(rep_mac), .rep_ipv4(rep_ipv4),
      .busy(a_busy), .done(a_done), .tx_dat(a_dat), .tx_val(a_val), .tx_rdy(tx_rdy),
      .tx_sof(a_sof), .tx_eof(a_eof), .tx_dst_mac(a_dst), .tx_ethertype(a_et)
   );

   arp_vlg_tx #(.PAD_LEN(0)) u_dut0 (
      .clk(clk), .rst(rst), .dev_mac(dev_mac), .dev_ipv4(dev_ipv4),
      .req_v(req_v), .req_ipv4(req_ipv4), .rep_v(rep_v), .rep_mac(rep_mac), .rep_ipv4(rep_ipv4),
      .busy(b_busy), .done(b_done), .tx_dat(b_dat), .tx_val(b_val), .tx_rdy(tx_rdy),
      .tx_sof(b_sof), .tx_eof(b_eof), .tx_dst_mac(b_dst), .tx_ethertype(b_et)
   );

   // Observed instance: 0 = default PAD_LEN, 1 = PAD_LEN 0
   logic        mon_sel = 1'b0;
   logic        m_val, m_sof, m_eof, m_busy, m_done;
   logic [7:0]  m_dat;
   logic [47:0] m_dst;
   assign m_val  = mon_sel ? b_val  : a_val;
   assign m_sof  = mon_sel ? b_sof  : a_sof;
   assign m_eof  = mon_sel ? b_eof  : a_eof;
   assign m_busy = mon_sel ? b_busy : a_busy;
   assign m_done = mon_sel ? b_done : a_done;
   assign m_dat  = mon_sel ? b_dat  : a_dat;
   assign m_dst  = mon_sel ? b_dst  : a_dst;

   int total = 0;
   int bad   = 0;

   logic [7:0]  exp_q[$];
   logic [7:0]  cap_bytes[$];
   bit          cap_sof[$];
   bit          cap_eof[$];
   logic [47:0] cap_dst;
   int          cap_dst_chg, cap_hold_bad, cap_wait;
   bit          cap_timeout;
   logic        post_done, post_val, post_busy;
   bit          rnd_rdy = 1'b0;

   // Expected frame from the ARP field list, padded with zeros up to len bytes.
   function automatic void build_frame(input bit rep, input logic [47:0] dm, input logic [31:0] di,
                                       input logic [47:0] tm, input logic [31:0] ti, input int len);
      exp_q.delete();
      exp_q.push_back(8'h00); exp_q.push_back(8'h01);
      exp_q.push_back(8'h08); exp_q.push_back(8'h00);
      exp_q.push_back(8'h06); exp_q.push_back(8'h04);
      exp_q.push_back(8'h00); exp_q.push_back(rep ? 8'h02 : 8'h01);
      for (int k = 5; k >= 0; k--) exp_q.push_back(dm[8*k +: 8]);
      for (int k = 3; k >= 0; k--) exp_q.push_back(di[8*k +: 8]);
      for (int k = 5; k >= 0; k--) exp_q.push_back(rep ? tm[8*k +: 8] : 8'h00);
      for (int k = 3; k >= 0; k--) exp_q.push_back(ti[8*k +: 8]);
      while (exp_q.size() < len) exp_q.push_back(8'h00);
   endfunction

   task automatic pulse(input bit do_req, input logic [31:0] rq_ip,
                        input bit do_rep, input logic [47:0] rp_mac, input logic [31:0] rp_ip);
      @(negedge clk);
      req_v = do_req; req_ipv4 = rq_ip;
      rep_v = do_rep; rep_mac = rp_mac; rep_ipv4 = rp_ip;
      @(posedge clk);
      #1;
      req_v = 1'b0; rep_v = 1'b0;
   endtask

   // Records one frame; tx_rdy is chosen on each falling edge for the following rising edge.
   task automatic capture();
      int         budget;
      bit         fin, holding;
      logic [7:0] h_dat;
      logic       h_sof, h_eof;
      cap_bytes.delete(); cap_sof.delete(); cap_eof.delete();
      cap_timeout = 0; cap_wait = 0; cap_hold_bad = 0; cap_dst_chg = 0;
      holding = 0; fin = 0; budget = 0; h_dat = '0; h_sof = 0; h_eof = 0;
      @(negedge clk);
      while (!m_val && cap_wait < 500) begin
         cap_wait++;
         @(negedge clk);
      end
      if (!m_val) begin
         cap_timeout = 1;
         return;
      end
      cap_dst = m_dst;
      while (!fin && budget < 2000) begin
         if (holding && (m_dat !== h_dat || m_sof !== h_sof || m_eof !== h_eof)) cap_hold_bad++;
         if (m_dst !== cap_dst) cap_dst_chg++;
         tx_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         holding = 0;
         if (m_val && tx_rdy) begin
            cap_bytes.push_back(m_dat);
            cap_sof.push_back(m_sof);
            cap_eof.push_back(m_eof);
            if (m_eof) fin = 1;
         end else if (m_val) begin
            holding = 1; h_dat = m_dat; h_sof = m_sof; h_eof = m_eof;
         end
         if (!fin) begin
            @(negedge clk);
            budget++;
         end
      end
      if (!fin) begin
         cap_timeout = 1;
         return;
      end
      @(negedge clk);
      post_done = m_done; post_val = m_val; post_busy = m_busy;
      tx_rdy = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({a_val, a_sof, a_eof, a_busy, a_done, a_dat, a_dst} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got val=%b sof=%b eof=%b busy=%b done=%b dat=%h dst=%h exp all zero",
                  a_val, a_sof, a_eof, a_busy, a_done, a_dat, a_dst);
      end
      total++;
      if (a_et !== 16'h0806 || b_et !== 16'h0806) begin
         bad++;
         $display("FAIL reset_ethertype got=%h/%h exp=0806", a_et, b_et);
      end
      rst = 1'b0;
   endtask

   task automatic test_request();
      dev_mac = 48'h02_00_00_00_00_01; dev_ipv4 = 32'hc0_a8_01_0a;
      rnd_rdy = 0; mon_sel = 0;
      pulse(1, 32'hc0_a8_01_01, 0, '0, '0);
      capture();
      build_frame(0, dev_mac, dev_ipv4, '0, 32'hc0_a8_01_01, 46);
      total++;
      if (cap_timeout || cap_bytes.size() != 46) begin
         bad++;
         $display("FAIL req_len got=%0d timeout=%0b exp=46", cap_bytes.size(), cap_timeout);
      end
      for (int i = 0; i < cap_bytes.size() && i < exp_q.size(); i++) begin
         total++;
         if ({cap_bytes[i], cap_sof[i], cap_eof[i]} !== {exp_q[i], i == 0, i == 45}) begin
            bad++;
            $display("FAIL req_byte[%0d] got=%h sof=%b eof=%b exp=%h sof=%b eof=%b",
                     i, cap_bytes[i], cap_sof[i], cap_eof[i], exp_q[i], i == 0, i == 45);
         end
      end
      total++;
      if (cap_dst !== 48'hffff_ffff_ffff || cap_dst_chg != 0) begin
         bad++;
         $display("FAIL req_dst got=%h changes=%0d exp=ffffffffffff", cap_dst, cap_dst_chg);
      end
      total++;
      if ({post_done, post_val, post_busy} !== 3'b100) begin
         bad++;
         $display("FAIL req_after_eof got done=%b val=%b busy=%b exp 1 0 0", post_done, post_val, post_busy);
      end
      @(negedge clk);
      total++;
      if (m_done !== 1'b0) begin
         bad++;
         $display("FAIL req_done_width got=%b exp=0", m_done);
      end
   endtask

   task automatic test_reply_priority();
      logic [47:0] rmac;
      logic [31:0] rip;
      rmac = 48'haa_bb_cc_dd_ee_ff; rip = 32'hc0_a8_01_05;
      pulse(1, 32'hc0_a8_01_01, 1, rmac, rip);
      capture();
      build_frame(1, dev_mac, dev_ipv4, rmac, rip, 46);
      total++;
      if (cap_timeout || cap_bytes.size() != 46) begin
         bad++;
         $display("FAIL prio_rep_len got=%0d timeout=%0b exp=46", cap_bytes.size(), cap_timeout);
      end
      for (int i = 0; i < cap_bytes.size() && i < exp_q.size(); i++) begin
         total++;
         if ({cap_bytes[i], cap_sof[i], cap_eof[i]} !== {exp_q[i], i == 0, i == 45}) begin
            bad++;
            $display("FAIL prio_rep_byte[%0d] got=%h exp=%h", i, cap_bytes[i], exp_q[i]);
         end
      end
      total++;
      if (cap_dst !== rmac || post_done !== 1'b1) begin
         bad++;
         $display("FAIL prio_rep_dst got=%h done=%b exp=%h done=1", cap_dst, post_done, rmac);
      end
      capture();
      build_frame(0, dev_mac, dev_ipv4, '0, 32'hc0_a8_01_01, 46);
      total++;
      if (cap_timeout || cap_wait != 0 || cap_bytes.size() != 46) begin
         bad++;
         $display("FAIL prio_req_gap got wait=%0d len=%0d exp wait=0 len=46", cap_wait, cap_bytes.size());
      end
      for (int i = 0; i < cap_bytes.size() && i < exp_q.size(); i++) begin
         total++;
         if (cap_bytes[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL prio_req_byte[%0d] got=%h exp=%h", i, cap_bytes[i], exp_q[i]);
         end
      end
      total++;
      if (cap_dst !== 48'hffff_ffff_ffff) begin
         bad++;
         $display("FAIL prio_req_dst got=%h exp=ffffffffffff", cap_dst);
      end
   endtask

   task automatic test_stall();
      rnd_rdy = 1;
      pulse(1, 32'hc0_a8_01_01, 0, '0, '0);
      capture();
      rnd_rdy = 0;
      build_frame(0, dev_mac, dev_ipv4, '0, 32'hc0_a8_01_01, 46);
      total++;
      if (cap_timeout || cap_bytes.size() != 46) begin
         bad++;
         $display("FAIL stall_len got=%0d timeout=%0b exp=46", cap_bytes.size(), cap_timeout);
      end
      for (int i = 0; i < cap_bytes.size() && i < exp_q.size(); i++) begin
         total++;
         if ({cap_bytes[i], cap_sof[i], cap_eof[i]} !== {exp_q[i], i == 0, i == 45}) begin
            bad++;
            $display("FAIL stall_byte[%0d] got=%h exp=%h", i, cap_bytes[i], exp_q[i]);
         end
      end
      total++;
      if (cap_hold_bad != 0) begin
         bad++;
         $display("FAIL stall_hold got=%0d unstable cycles exp=0", cap_hold_bad);
      end
   endtask

   task automatic test_overwrite();
      fork
         capture();
         begin
            pulse(1, 32'hc0_a8_01_63, 0, '0, '0);
            repeat (5) @(posedge clk);
            total++;
            if (m_busy !== 1'b1) begin
               bad++;
               $display("FAIL ovw_busy got=%b exp=1", m_busy);
            end
            pulse(1, 32'h0a_00_00_01, 0, '0, '0);
            repeat (3) @(posedge clk);
            pulse(1, 32'h0a_00_00_02, 0, '0, '0);
         end
      join
      build_frame(0, dev_mac, dev_ipv4, '0, 32'hc0_a8_01_63, 46);
      total++;
      if (cap_timeout || cap_bytes.size() != 46 || cap_bytes[27] !== exp_q[27]) begin
         bad++;
         $display("FAIL ovw_first got len=%0d tpa_lo=%h exp len=46 tpa_lo=%h",
                  cap_bytes.size(), cap_bytes[27], exp_q[27]);
      end
      capture();
      build_frame(0, dev_mac, dev_ipv4, '0, 32'h0a_00_00_02, 46);
      for (int i = 0; i < 46; i++) begin
         total++;
         if (cap_timeout || i >= cap_bytes.size() || cap_bytes[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL ovw_second_byte[%0d] got=%h exp=%h", i,
                     (i < cap_bytes.size()) ? cap_bytes[i] : 8'hxx, exp_q[i]);
         end
      end
      begin
         int extra;
         extra = 0;
         repeat (100) begin
            @(negedge clk);
            if (m_val) extra++;
         end
         total++;
         if (extra != 0) begin
            bad++;
            $display("FAIL ovw_no_third got=%0d valid cycles exp=0", extra);
         end
      end
   endtask

   task automatic test_random();
      bit          rep;
      logic [47:0] rmac;
      logic [31:0] rip;
      rnd_rdy = 1;
      for (int n = 0; n < 6; n++) begin
         dev_mac  = {$urandom, $urandom} & 48'hffff_ffff_ffff;
         dev_ipv4 = $urandom;
         rmac     = {$urandom, $urandom} & 48'hffff_ffff_ffff;
         rip      = $urandom;
         rep      = 1'($urandom_range(0, 1));
         pulse(!rep, rip, rep, rmac, rip);
         capture();
         build_frame(rep, dev_mac, dev_ipv4, rmac, rip, 46);
         total++;
         if (cap_timeout || cap_bytes.size() != 46 || cap_hold_bad != 0 ||
             cap_dst !== (rep ? rmac : 48'hffff_ffff_ffff)) begin
            bad++;
            $display("FAIL rnd%0d_frame got len=%0d hold=%0d dst=%h exp len=46 hold=0 dst=%h",
                     n, cap_bytes.size(), cap_hold_bad, cap_dst, rep ? rmac : 48'hffff_ffff_ffff);
         end
         for (int i = 0; i < cap_bytes.size() && i < exp_q.size(); i++) begin
            total++;
            if ({cap_bytes[i], cap_sof[i], cap_eof[i]} !== {exp_q[i], i == 0, i == 45}) begin
               bad++;
               $display("FAIL rnd%0d_byte[%0d] got=%h exp=%h", n, i, cap_bytes[i], exp_q[i]);
            end
         end
      end
      rnd_rdy = 0;
      tx_rdy = 1'b1;
   endtask

   task automatic test_reset_mid();
      int seen;
      tx_rdy = 1'b1;
      pulse(1, 32'h0a_00_00_09, 0, '0, '0);
      pulse(0, '0, 1, 48'h11_22_33_44_55_66, 32'h0a_00_00_07);
      repeat (10) @(negedge clk);
      total++;
      if (a_busy !== 1'b1 || a_val !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_inframe got busy=%b val=%b exp 1 1", a_busy, a_val);
      end
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({a_val, a_sof, a_eof, a_busy, a_done, a_dat, a_dst} !== '0) begin
         bad++;
         $display("FAIL rstmid_outputs got val=%b busy=%b done=%b dat=%h dst=%h exp all zero",
                  a_val, a_busy, a_done, a_dat, a_dst);
      end
      rst = 1'b0;
      seen = 0;
      repeat (100) begin
         @(negedge clk);
         if (a_val || a_done) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("FAIL rstmid_no_frame got=%0d active cycles exp=0", seen);
      end
   endtask

   task automatic test_no_pad();
      mon_sel = 1; rnd_rdy = 1;
      dev_mac = 48'h02_00_00_00_00_01; dev_ipv4 = 32'hc0_a8_01_0a;
      pulse(1, 32'hc0_a8_01_01, 0, '0, '0);
      capture();
      rnd_rdy = 0;
      build_frame(0, dev_mac, dev_ipv4, '0, 32'hc0_a8_01_01, 28);
      total++;
      if (cap_timeout || cap_bytes.size() != 28) begin
         bad++;
         $display("FAIL nopad_len got=%0d timeout=%0b exp=28", cap_bytes.size(), cap_timeout);
      end
      for (int i = 0; i < cap_bytes.size() && i < exp_q.size(); i++) begin
         total++;
         if ({cap_bytes[i], cap_sof[i], cap_eof[i]} !== {exp_q[i], i == 0, i == 27}) begin
            bad++;
            $display("FAIL nopad_byte[%0d] got=%h sof=%b eof=%b exp=%h sof=%b eof=%b",
                     i, cap_bytes[i], cap_sof[i], cap_eof[i], exp_q[i], i == 0, i == 27);
         end
      end
      total++;
      if ({post_done, post_val, post_busy} !== 3'b100 || cap_dst !== 48'hffff_ffff_ffff) begin
         bad++;
         $display("FAIL nopad_end got done=%b val=%b busy=%b dst=%h exp 1 0 0 ffffffffffff",
                  post_done, post_val, post_busy, cap_dst);
      end
   endtask

   initial begin
      test_reset();
      test_request();
      test_reply_priority();
      test_stall();
      test_overwrite();
      test_random();
      test_reset_mid();
      test_no_pad();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
